// File: rtl/pipeline_hazard_ctrl_pkg.sv
// hazard_pkg: shared types and helpers for the pipeline hazard controller.
// FSM state encoding, register-index width, the x0 constant and the
// load-use compare. Optional build macro used elsewhere: HAZARD_PERF_EN.
package hazard_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] X0 = 5'd0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } hz_state_t;

  // A load in EX writes a register the ID instruction reads. x0 never hazards.
  function automatic logic load_use_f(
    input logic [REG_AW-1:0] rs1,
    input logic [REG_AW-1:0] rs2,
    input logic              use_rs1,
    input logic              use_rs2,
    input logic [REG_AW-1:0] rd,
    input logic              is_load
  );
    return is_load & (rd != X0) &
           ((use_rs1 & (rs1 == rd)) | (use_rs2 & (rs2 == rd)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: bundle between the pipeline/caches (master) and
// the hazard controller (slave). With HAZARD_PERF_EN defined it also
// carries the performance-counter clear and the four counter values.
//
// Handshake semantics: there is no valid/ready pair here. imiss/dmiss are
// levels held for as long as the miss is outstanding; iready/dready are
// single-cycle refill-complete pulses and are only meaningful while the
// controller waits on the matching cache; stall/takebranch/backend_hold
// are per-cycle levels and iabort is a single-cycle pulse.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = hazard_pkg::REG_AW
);
  import hazard_pkg::*;

  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_is_load;
  logic              ex_branch_taken;
  logic              imiss;
  logic              iready;
  logic              dmiss;
  logic              dready;
  logic              stall;
  logic              takebranch;
  logic              backend_hold;
  logic              iabort;
  logic [1:0]        state_o;
  logic              timeout_err;

`ifdef HAZARD_PERF_EN
  logic              perf_clear;
  logic [31:0]       perf_lu_cycles;
  logic [31:0]       perf_imiss_cycles;
  logic [31:0]       perf_dmiss_cycles;
  logic [31:0]       perf_flushes;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_branch_taken, imiss, iready, dmiss, dready, perf_clear,
    input  stall, takebranch, backend_hold, iabort, state_o, timeout_err,
           perf_lu_cycles, perf_imiss_cycles, perf_dmiss_cycles, perf_flushes
  );
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_branch_taken, imiss, iready, dmiss, dready, perf_clear,
    output stall, takebranch, backend_hold, iabort, state_o, timeout_err,
           perf_lu_cycles, perf_imiss_cycles, perf_dmiss_cycles, perf_flushes
  );
`else
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_branch_taken, imiss, iready, dmiss, dready,
    input  stall, takebranch, backend_hold, iabort, state_o, timeout_err
  );
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_branch_taken, imiss, iready, dmiss, dready,
    output stall, takebranch, backend_hold, iabort, state_o, timeout_err
  );
`endif

endinterface

// File: rtl/pipeline_hazard_ctrl_perf_counters.sv
// hazard_perf_counters: four saturating 32-bit event counters with a
// synchronous clear that beats increment. Only instantiated when
// HAZARD_PERF_EN is defined.
module hazard_perf_counters
  import hazard_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_inc_lu,
  input  logic        i_inc_imiss,
  input  logic        i_inc_dmiss,
  input  logic        i_inc_flush,
  output logic [31:0] o_lu_cycles,
  output logic [31:0] o_imiss_cycles,
  output logic [31:0] o_dmiss_cycles,
  output logic [31:0] o_flushes
);

  logic [31:0] r_cnt [4];
  logic [3:0]  w_inc;

  assign w_inc = {i_inc_flush, i_inc_dmiss, i_inc_imiss, i_inc_lu};

  // Count events, sticking at all-ones; clear has priority over counting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (i_clear)                          r_cnt[i] <= '0;
        else if (w_inc[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + 32'd1;
      end
    end
  end

  assign o_lu_cycles    = r_cnt[0];
  assign o_imiss_cycles = r_cnt[1];
  assign o_dmiss_cycles = r_cnt[2];
  assign o_flushes      = r_cnt[3];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for the 5-stage RV32 pipeline.
// Mealy outputs in RUN so holds act in the cycle the event is seen; wait
// states sequence I-cache and D-cache refills, with an I-miss queued behind
// a D-miss via r_pend_i. A saturating wait counter raises a sticky
// timeout_err but never fakes a refill.
// Optional macro HAZARD_PERF_EN adds performance counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW       = hazard_pkg::REG_AW,
  parameter int MISS_TIMEOUT = 1023
) (
  input logic                   clock,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int CNT_W = ($clog2(MISS_TIMEOUT + 1) > 10) ? $clog2(MISS_TIMEOUT + 1) : 10;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(MISS_TIMEOUT);

  hz_state_t         r_state;
  hz_state_t         w_state_nxt;
  logic              r_pend_i;
  logic              w_pend_i_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_sat;
  logic              r_timeout_err;
  logic              w_in_wait;
  logic              w_trans;
  logic [REG_AW-1:0] w_id_rs1;
  logic [REG_AW-1:0] w_id_rs2;
  logic [REG_AW-1:0] w_ex_rd;
  logic              w_load_use;
  logic              w_stall;
  logic              w_takebranch;
  logic              w_backend_hold;
  logic              w_iabort;

  assign w_id_rs1   = hz.id_rs1;
  assign w_id_rs2   = hz.id_rs2;
  assign w_ex_rd    = hz.ex_rd;
  assign w_load_use = load_use_f(w_id_rs1, w_id_rs2, hz.id_use_rs1, hz.id_use_rs2,
                                 w_ex_rd, hz.ex_is_load);

  // State register and queued I-miss flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= RUN;
      r_pend_i <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pend_i <= w_pend_i_nxt;
    end
  end

  // Next state: D-miss first (it freezes the back end, so the branch in EX
  // waits), then branch (squashes the wrong-path fetch), then I-miss.
  always_comb begin
    w_state_nxt  = r_state;
    w_pend_i_nxt = r_pend_i;
    case (r_state)
      RUN: begin
        if (hz.dmiss) begin
          w_state_nxt  = D_WAIT;
          w_pend_i_nxt = hz.imiss & ~hz.ex_branch_taken;
        end else if (!hz.ex_branch_taken && hz.imiss) begin
          w_state_nxt  = I_WAIT;
        end
      end
      I_WAIT: begin
        if (hz.dmiss) begin
          // The fetch is still owed unless it completes or is aborted now.
          w_state_nxt  = D_WAIT;
          w_pend_i_nxt = ~hz.iready & ~hz.ex_branch_taken;
        end else if (hz.ex_branch_taken || hz.iready) begin
          w_state_nxt  = RUN;
        end
      end
      D_WAIT: begin
        if (hz.dready) begin
          w_state_nxt  = r_pend_i ? I_WAIT : RUN;
          w_pend_i_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = RUN;
        w_pend_i_nxt = 1'b0;
      end
    endcase
  end

  // Outputs: Mealy priority chain in RUN, fixed holds in the wait states.
  always_comb begin
    w_stall        = 1'b0;
    w_takebranch   = 1'b0;
    w_backend_hold = 1'b0;
    w_iabort       = 1'b0;
    case (r_state)
      RUN: begin
        if (hz.dmiss) begin
          w_stall        = 1'b1;
          w_backend_hold = 1'b1;
        end else if (hz.ex_branch_taken) begin
          w_takebranch   = 1'b1;
          w_iabort       = hz.imiss;
        end else if (hz.imiss || w_load_use) begin
          w_stall        = 1'b1;
        end
      end
      I_WAIT: begin
        w_stall      = 1'b1;
        w_takebranch = hz.ex_branch_taken;
        w_iabort     = hz.ex_branch_taken;
      end
      D_WAIT: begin
        w_stall        = 1'b1;
        w_backend_hold = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_in_wait = (r_state != RUN);
  assign w_trans   = (w_state_nxt != r_state);
  assign w_cnt_sat = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  // Wait-cycle counter and sticky timeout flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_trans) begin
        r_cnt <= '0;
      end else if (w_in_wait) begin
        r_cnt <= w_cnt_sat;
        if (w_cnt_sat >= TO_VAL) r_timeout_err <= 1'b1;
      end
    end
  end

  assign hz.stall        = w_stall;
  assign hz.takebranch   = w_takebranch;
  assign hz.backend_hold = w_backend_hold;
  assign hz.iabort       = w_iabort;
  assign hz.state_o      = r_state;
  assign hz.timeout_err  = r_timeout_err;

`ifdef HAZARD_PERF_EN
  logic w_lu_stall;
  // In RUN, a stall not caused by either miss is a load-use bubble.
  assign w_lu_stall = (r_state == RUN) & w_stall & ~hz.dmiss & ~hz.imiss;

  hazard_perf_counters u_perf (
    .clock          (clock),
    .reset          (reset),
    .i_clear        (hz.perf_clear),
    .i_inc_lu       (w_lu_stall),
    .i_inc_imiss    (r_state == I_WAIT),
    .i_inc_dmiss    (r_state == D_WAIT),
    .i_inc_flush    (w_takebranch),
    .o_lu_cycles    (hz.perf_lu_cycles),
    .o_imiss_cycles (hz.perf_imiss_cycles),
    .o_dmiss_cycles (hz.perf_dmiss_cycles),
    .o_flushes      (hz.perf_flushes)
  );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus a randomized run
// checked against a flag-based behavioural model. Output vectors are packed
// as {stall, takebranch, backend_hold, iabort, state_o[1:0], timeout_err}.
// Perf-counter checks are compiled only with HAZARD_PERF_EN.
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  localparam int TO = 8;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(.MISS_TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .hz    (hz)
  );

  // clock / reset
  always #5 clock = ~clock;

  function automatic logic [6:0] outs();
    return {hz.stall, hz.takebranch, hz.backend_hold, hz.iabort, hz.state_o, hz.timeout_err};
  endfunction

  function automatic logic [6:0] pk(input bit s, input bit tb, input bit h, input bit ab,
                                    input int st, input bit to);
    logic [1:0] st2;
    st2 = st[1:0];
    return {s, tb, h, ab, st2, to};
  endfunction

  // driver tasks
  task automatic idle();
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
    hz.ex_rd = '0; hz.ex_is_load = 1'b0; hz.ex_branch_taken = 1'b0;
    hz.imiss = 1'b0; hz.iready = 1'b0; hz.dmiss = 1'b0; hz.dready = 1'b0;
`ifdef HAZARD_PERF_EN
    hz.perf_clear = 1'b0;
`endif
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] o;
    idle();
    reset = 1'b1;
    @(negedge clock);
    #1;
    o = outs();
    n_checks++;
    if (o !== pk(0,0,0,0,0,0)) begin n_fail++; $display("FAIL reset_state: got %b want %b", o, pk(0,0,0,0,0,0)); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    logic [6:0] o;
    idle();
    hz.ex_is_load = 1'b1; hz.ex_rd = 5'd5; hz.id_rs1 = 5'd5; hz.id_use_rs1 = 1'b1;
    #1; o = outs(); n_checks++;
    if (o !== pk(1,0,0,0,0,0)) begin n_fail++; $display("FAIL lu_rs1_hit: got %b want %b", o, pk(1,0,0,0,0,0)); end
    tick();
    hz.ex_is_load = 1'b0;   // load moved on, bubble in EX
    #1; o = outs(); n_checks++;
    if (o !== pk(0,0,0,0,0,0)) begin n_fail++; $display("FAIL lu_one_cycle: got %b want %b", o, pk(0,0,0,0,0,0)); end
    tick();
    idle();
    hz.ex_is_load = 1'b1; hz.ex_rd = 5'd0; hz.id_rs1 = 5'd0; hz.id_use_rs1 = 1'b1;
    #1; o = outs(); n_checks++;
    if (o !== pk(0,0,0,0,0,0)) begin n_fail++; $display("FAIL lu_x0: got %b want %b", o, pk(0,0,0,0,0,0)); end
    tick();
    idle();
    hz.ex_is_load = 1'b1; hz.ex_rd = 5'd9; hz.id_rs2 = 5'd9; hz.id_use_rs2 = 1'b1;
    #1; o = outs(); n_checks++;
    if (o !== pk(1,0,0,0,0,0)) begin n_fail++; $display("FAIL lu_rs2_hit: got %b want %b", o, pk(1,0,0,0,0,0)); end
    tick();
    hz.id_use_rs2 = 1'b0;   // match but operand unused
    #1; o = outs(); n_checks++;
    if (o !== pk(0,0,0,0,0,0)) begin n_fail++; $display("FAIL lu_unused: got %b want %b", o, pk(0,0,0,0,0,0)); end
    tick();
    idle();
  endtask

  task automatic test_branch_beats_hazard();
    logic [6:0] o;
    idle();
    hz.ex_is_load = 1'b1; hz.ex_rd = 5'd5; hz.id_rs1 = 5'd5; hz.id_use_rs1 = 1'b1;
    hz.ex_branch_taken = 1'b1; hz.imiss = 1'b1;
    #1; o = outs(); n_checks++;
    if (o !== pk(0,1,0,1,0,0)) begin n_fail++; $display("FAIL branch_prio: got %b want %b", o, pk(0,1,0,1,0,0)); end
    tick();
    idle();
    #1; o = outs(); n_checks++;
    if (o !== pk(0,0,0,0,0,0)) begin n_fail++; $display("FAIL branch_stays_run: got %b want %b", o, pk(0,0,0,0,0,0)); end
    tick();
  endtask

  task automatic test_imiss();
    logic [6:0] o;
    idle();
    hz.imiss = 1'b1;
    #1; o = outs(); n_checks++;
    if (o !== pk(1,0,0,0,0,0)) begin n_fail++; $display("FAIL imiss_c0: got %b want %b", o, pk(1,0,0,0,0,0)); end
    tick();
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) hz.iready = 1'b1;
      #1; o = outs(); n_checks++;
      if (o !== pk(1,0,0,0,1,0)) begin n_fail++; $display("FAIL imiss_wait c%0d: got %b want %b", c, o, pk(1,0,0,0,1,0)); end
      tick();
    end
    idle();
    #1; o = outs(); n_checks++;
    if (o !== pk(0,0,0,0,0,0)) begin n_fail++; $display("FAIL imiss_c7: got %b want %b", o, pk(0,0,0,0,0,0)); end
    tick();
  endtask

  task automatic test_dual_miss();
    logic [6:0] o;
    idle();
    hz.dmiss = 1'b1; hz.imiss = 1'b1;
    #1; o = outs(); n_checks++;
    if (o !== pk(1,0,1,0,0,0)) begin n_fail++; $display("FAIL dual_c0: got %b want %b", o, pk(1,0,1,0,0,0)); end
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) hz.dready = 1'b1;
      #1; o = outs(); n_checks++;
      if (o !== pk(1,0,1,0,2,0)) begin n_fail++; $display("FAIL dual_dwait c%0d: got %b want %b", c, o, pk(1,0,1,0,2,0)); end
      tick();
    end
    hz.dready = 1'b0; hz.dmiss = 1'b0;
    for (int c = 5; c <= 8; c++) begin
      if (c == 8) hz.iready = 1'b1;
      #1; o = outs(); n_checks++;
      if (o !== pk(1,0,0,0,1,0)) begin n_fail++; $display("FAIL dual_iwait c%0d: got %b want %b", c, o, pk(1,0,0,0,1,0)); end
      tick();
    end
    idle();
    #1; o = outs(); n_checks++;
    if (o !== pk(0,0,0,0,0,0)) begin n_fail++; $display("FAIL dual_c9: got %b want %b", o, pk(0,0,0,0,0,0)); end
    tick();
  endtask

  task automatic test_iwait_branch_and_stray();
    logic [6:0] o;
    idle();
    hz.iready = 1'b1; hz.dready = 1'b1;   // refill pulses while in RUN
    #1; o = outs(); n_checks++;
    if (o !== pk(0,0,0,0,0,0)) begin n_fail++; $display("FAIL stray_ready: got %b want %b", o, pk(0,0,0,0,0,0)); end
    tick();
    idle();
    hz.imiss = 1'b1;
    tick();
    tick();
    hz.ex_branch_taken = 1'b1;
    #1; o = outs(); n_checks++;
    if (o !== pk(1,1,0,1,1,0)) begin n_fail++; $display("FAIL iwait_branch: got %b want %b", o, pk(1,1,0,1,1,0)); end
    tick();
    idle();
    #1; o = outs(); n_checks++;
    if (o !== pk(0,0,0,0,0,0)) begin n_fail++; $display("FAIL iwait_branch_exit: got %b want %b", o, pk(0,0,0,0,0,0)); end
    tick();
  endtask

  task automatic test_timeout();
    logic [6:0] o;
    idle();
    hz.dmiss = 1'b1;
    tick();
    for (int c = 1; c <= 12; c++) begin
      #1; o = outs(); n_checks++;
      if (o !== pk(1,0,1,0,2,(c >= 9))) begin
        n_fail++; $display("FAIL timeout c%0d: got %b want %b", c, o, pk(1,0,1,0,2,(c >= 9)));
      end
      tick();
    end
    #2;
    reset = 1'b1; hz.dmiss = 1'b0;
    #1; o = outs(); n_checks++;
    if (o !== pk(0,0,0,0,0,0)) begin n_fail++; $display("FAIL async_reset: got %b want %b", o, pk(0,0,0,0,0,0)); end
    @(negedge clock);
    reset = 1'b0;
    #1; o = outs(); n_checks++;
    if (o !== pk(0,0,0,0,0,0)) begin n_fail++; $display("FAIL after_reset: got %b want %b", o, pk(0,0,0,0,0,0)); end
    tick();
  endtask

  // Randomized run against a model tracking "waiting on I / on D" flags.
  task automatic test_random();
    bit m_wi, m_wd, m_q, m_err;
    bit n_wi, n_wd, n_q;
    int m_cnt;
    bit lu, br;
    logic [6:0] o, e;
    bit es, et, eh, ea;
    int est;
    for (int i = 0; i < 800; i++) begin
      if (i % 200 == 0) begin
        do_reset();
        m_wi = 0; m_wd = 0; m_q = 0; m_err = 0; m_cnt = 0;
      end
      hz.id_rs1          = 5'($urandom_range(0, 3));
      hz.id_rs2          = 5'($urandom_range(0, 3));
      hz.ex_rd           = 5'($urandom_range(0, 3));
      hz.id_use_rs1      = ($urandom_range(0, 1) == 1);
      hz.id_use_rs2      = ($urandom_range(0, 1) == 1);
      hz.ex_is_load      = ($urandom_range(0, 1) == 1);
      hz.ex_branch_taken = ($urandom_range(0, 99) < 10);
      hz.imiss           = ($urandom_range(0, 99) < 15);
      hz.iready          = ($urandom_range(0, 99) < 15);
      hz.dmiss           = ($urandom_range(0, 99) < 8);
      hz.dready          = ($urandom_range(0, 99) < 20);
      #1;
      br = hz.ex_branch_taken;
      lu = hz.ex_is_load && (hz.ex_rd != 0) &&
           ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) || (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));
      es = 0; et = 0; eh = 0; ea = 0; est = 0;
      n_wi = m_wi; n_wd = m_wd; n_q = m_q;
      if (m_wd) begin
        es = 1; eh = 1; est = 2;
        if (hz.dready) begin n_wd = 0; n_wi = m_q; n_q = 0; end
      end else if (m_wi) begin
        es = 1; et = br; ea = br; est = 1;
        if (hz.dmiss) begin n_wi = 0; n_wd = 1; n_q = !hz.iready && !br; end
        else if (br || hz.iready) n_wi = 0;
      end else begin
        if (hz.dmiss) begin es = 1; eh = 1; n_wd = 1; n_q = hz.imiss && !br; end
        else if (br) begin et = 1; ea = hz.imiss; end
        else if (hz.imiss) begin es = 1; n_wi = 1; end
        else if (lu) es = 1;
      end
      e = pk(es, et, eh, ea, est, m_err);
      o = outs();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL random cyc%0d: got %b want %b", i, o, e); end
      tick();
      if ((n_wi != m_wi) || (n_wd != m_wd)) m_cnt = 0;
      else if (m_wi || m_wd) begin
        if (m_cnt < 1023) m_cnt++;
        if (m_cnt >= TO) m_err = 1;
      end
      m_wi = n_wi; m_wd = n_wd; m_q = n_q;
    end
    do_reset();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    idle();
    hz.perf_clear = 1'b1;
    tick();
    hz.perf_clear = 1'b0;
    #1; n_checks++;
    if ({hz.perf_lu_cycles, hz.perf_imiss_cycles, hz.perf_dmiss_cycles, hz.perf_flushes} !== 128'd0) begin
      n_fail++; $display("FAIL perf_clear0: got %0d %0d %0d %0d want 0 0 0 0", hz.perf_lu_cycles,
                          hz.perf_imiss_cycles, hz.perf_dmiss_cycles, hz.perf_flushes);
    end
    hz.imiss = 1'b1;
    tick();
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) hz.iready = 1'b1;
      tick();
    end
    idle();
    hz.ex_branch_taken = 1'b1;
    tick();
    idle();
    #1; n_checks++;
    if (hz.perf_imiss_cycles !== 32'd6 || hz.perf_flushes !== 32'd1 ||
        hz.perf_lu_cycles !== 32'd0 || hz.perf_dmiss_cycles !== 32'd0) begin
      n_fail++; $display("FAIL perf_counts: got lu=%0d im=%0d dm=%0d fl=%0d want 0 6 0 1", hz.perf_lu_cycles,
                          hz.perf_imiss_cycles, hz.perf_dmiss_cycles, hz.perf_flushes);
    end
    hz.perf_clear = 1'b1;
    tick();
    hz.perf_clear = 1'b0;
    #1; n_checks++;
    if ({hz.perf_lu_cycles, hz.perf_imiss_cycles, hz.perf_dmiss_cycles, hz.perf_flushes} !== 128'd0) begin
      n_fail++; $display("FAIL perf_clear1: got %0d %0d %0d %0d want 0 0 0 0", hz.perf_lu_cycles,
                          hz.perf_imiss_cycles, hz.perf_dmiss_cycles, hz.perf_flushes);
    end
    tick();
  endtask
`endif

  // sequence + final report
  initial begin
    test_reset();
    test_load_use();
    test_branch_beats_hazard();
    test_imiss();
    test_dual_miss();
    test_iwait_branch_and_stray();
    test_timeout();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
